// File: rtl/mat_vec_pkg.sv
// mat_vec_pkg: shared types, constants and operand slicing helpers for the matrix-vector sequencer
package mat_vec_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef logic [1:0] row_tag_t;
  localparam int NUM_ROWS = 4;
  function automatic int row_lsb(input int r, input int w);
    return NUM_ROWS * r * w;
  endfunction
  function automatic int elem_lsb(input int r, input int c, input int w);
    return (NUM_ROWS * r + c) * w;
  endfunction
  function automatic int vec_lsb(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/dot_product.sv
// dot_product: 3-cycle 4-element signed dot product (operand regs, truncated products, wrapping sum)
module dot_product #(
  parameter int WIDTH = 32,
  parameter bit FIXED_POINT = 1
) (
  input  logic               clk_in,
  input  logic [4*WIDTH-1:0] x,
  input  logic [4*WIDTH-1:0] y,
  output logic [WIDTH-1:0]   z
);
  localparam int PW = 2 * WIDTH;
  localparam int SH = FIXED_POINT ? WIDTH / 2 : 0;
  logic [4*WIDTH-1:0] xr, yr;
  logic [WIDTH-1:0] p [4];
  // register operands, then products kept at bits [SH+WIDTH-1:SH], then a wrapping sum
  always_ff @(posedge clk_in) begin
    xr <= x;
    yr <= y;
    for (int i = 0; i < 4; i++)
      p[i] <= WIDTH'((PW'($signed(xr[i*WIDTH +: WIDTH])) * PW'($signed(yr[i*WIDTH +: WIDTH]))) >>> SH);
    z <= p[0] + p[1] + p[2] + p[3];
  end
endmodule

// File: rtl/mat_vec_tag_pipe.sv
// mat_vec_tag_pipe: DEPTH-deep valid+row-tag shift register tracking results in flight through a dot product
module mat_vec_tag_pipe
  import mat_vec_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     clr,
  input  logic     push,
  input  row_tag_t push_tag,
  output logic     pop,
  output row_tag_t pop_tag,
  output logic     pending
);
  logic [DEPTH-1:0] vld;
  row_tag_t tag [DEPTH];
  // shift tags alongside the datapath; reset or clear drops everything in flight
  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      vld <= '0;
      tag <= '{default: '0};
    end else begin
      vld <= {vld[DEPTH-2:0], push};
      tag[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) tag[i] <= tag[i-1];
    end
  end
  assign pop = vld[DEPTH-1];
  assign pop_tag = tag[DEPTH-1];
  assign pending = |vld[DEPTH-2:0];
endmodule

// File: rtl/mat_vec_sequencer.sv
// mat_vec_sequencer: 4x4 matrix x 4-vector over one shared dot product; MAT_VEC_AFFINE_EN issues rows 0..2 and passes v[3] through
module mat_vec_sequencer
  import mat_vec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DP_LATENCY = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [16*WIDTH-1:0] m_in,
  input  logic [4*WIDTH-1:0]  v_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*WIDTH-1:0]  out_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);
`ifdef MAT_VEC_AFFINE_EN
  localparam int ISSUE_ROWS = NUM_ROWS - 1;
`else
  localparam int ISSUE_ROWS = NUM_ROWS;
`endif
  localparam row_tag_t LAST_ROW = row_tag_t'(ISSUE_ROWS - 1);
  state_t state, state_nx;
  row_tag_t row, pop_tag;
  logic [16*WIDTH-1:0] m_reg;
  logic [4*WIDTH-1:0] v_reg, res, dp_x;
  logic [WIDTH-1:0] dp_z;
  logic accept, issue, pop, pending;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_vec = res;
  assign accept = in_valid & in_ready;
  assign issue = state == ISSUE;
  assign dp_x = m_reg[row_lsb(int'(row), WIDTH) +: 4*WIDTH];
  // next state: latch job, issue one row per cycle, drain the tag pipe, hold result until taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = (row == LAST_ROW) ? DRAIN : ISSUE;
      DRAIN:   state_nx = pending ? DRAIN : DONE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state, row counter, latched operands and result slots written by returning tags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      row <= '0;
      res <= '0;
      m_reg <= '0;
      v_reg <= '0;
    end else begin
      state <= state_nx;
      row <= issue ? row + 1'b1 : '0;
      if (accept) begin
        m_reg <= m_in;
        v_reg <= v_in;
      end
      if (pop) res[vec_lsb(int'(pop_tag), WIDTH) +: WIDTH] <= dp_z;
`ifdef MAT_VEC_AFFINE_EN
      if (accept) res[vec_lsb(NUM_ROWS - 1, WIDTH) +: WIDTH] <= v_in[vec_lsb(NUM_ROWS - 1, WIDTH) +: WIDTH];
`endif
    end
  end
  dot_product #(.WIDTH(WIDTH), .FIXED_POINT(1)) u_dp (
    .clk_in (clk_in),
    .x      (dp_x),
    .y      (v_reg),
    .z      (dp_z)
  );
  mat_vec_tag_pipe #(.DEPTH(DP_LATENCY)) u_tags (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr      (accept),
    .push     (issue),
    .push_tag (row),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .pending  (pending)
  );
endmodule

// File: tb/tb_mat_vec_sequencer.sv
// tb_mat_vec_sequencer: table-driven and sequence checks of mat_vec_sequencer against a scoreboard
module tb_mat_vec_sequencer;
  localparam int W = 32;
`ifdef MAT_VEC_AFFINE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 8;
`endif
  localparam logic [W-1:0] ONE = 32'h0001_0000;
  typedef logic [16*W-1:0] mat_t;
  typedef logic [4*W-1:0] vec_t;
  typedef struct {
    mat_t m;
    vec_t v;
    vec_t e;
  } rec_t;
  logic clk_in = 0;
  logic rst_in, in_valid, in_ready, out_valid, out_ready, busy;
  mat_t m_in;
  vec_t v_in, out_vec, cur_exp, snap;
  int n_chk = 0, n_fail = 0, n_acc = 0, cyc = 0, n0;
  vec_t sb[$];
  int acc_q[$];
  rec_t tbl[$];
  mat_t bm[3];
  vec_t bv[3];
  mat_t tm;

  mat_vec_sequencer #(.WIDTH(W), .DP_LATENCY(3)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .m_in      (m_in),
    .v_in      (v_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t vec4(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction
  function automatic mat_t diag(input logic [W-1:0] d);
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[5*i*W +: W] = d;
    return m;
  endfunction
  function automatic mat_t fill(input logic [W-1:0] d);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = d;
    return m;
  endfunction
  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < 16; i++) m[i*W +: W] = $urandom;
    return m;
  endfunction
  function automatic vec_t rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic vec_t adj(input vec_t e, input vec_t v);
    vec_t r;
    r = e;
`ifdef MAT_VEC_AFFINE_EN
    r[3*W +: W] = v[3*W +: W];
`endif
    return r;
  endfunction
  function automatic vec_t model(input mat_t m, input vec_t v);
    vec_t e;
    logic signed [W-1:0] a, b;
    logic signed [2*W-1:0] p;
    logic [W-1:0] acc;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        a = m[(4*r+c)*W +: W];
        b = v[c*W +: W];
        p = a * b;
        acc = acc + p[3*W/2-1:W/2];
      end
      e[r*W +: W] = acc;
    end
    return adj(e, v);
  endfunction

  // handshake monitor: push expectation on accept, compare on output handshake
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else chk("out_vec", out_vec, sb.pop_front());
      end
    end
  end

  task automatic send(input mat_t m, input vec_t v, input vec_t e);
    int k0;
    k0 = n_acc;
    m_in = m;
    v_in = v;
    cur_exp = e;
    in_valid = 1;
    for (int i = 0; i < 40 && n_acc == k0; i++) begin
      @(posedge clk_in);
      #1;
    end
    in_valid = 0;
    chk("accepted", n_acc - k0, 1);
  endtask

  task automatic wait_out();
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk_in);
    chk("out_valid_seen", out_valid, 1);
    chk("latency", cyc - acc_q[$], LAT);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1;
    in_valid = 0;
    out_ready = 0;
    m_in = '0;
    v_in = '0;
    cur_exp = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_vec", out_vec, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk_in);
    #1;
    rst_in = 0;
    out_ready = 1;
    tbl.push_back('{diag(ONE), vec4(ONE, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000),
                    adj(vec4(32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000),
                        vec4(ONE, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000))});
    tbl.push_back('{fill(32'h0002_0000), vec4(ONE, ONE, ONE, ONE),
                    adj({4{32'h0008_0000}}, vec4(ONE, ONE, ONE, ONE))});
    tm = '0;
    tbl.push_back('{tm, vec4(ONE, 32'h1234_5678, 32'h8000_0000, 32'h0003_0000),
                    adj('0, vec4(ONE, 32'h1234_5678, 32'h8000_0000, 32'h0003_0000))});
    tbl.push_back('{diag(ONE), vec_t'(0), vec_t'(0)});
    for (int i = 0; i < 2; i++) begin
      tm = rand_mat();
      snap = rand_vec();
      tbl.push_back('{tm, snap, model(tm, snap)});
    end
`ifdef MAT_VEC_AFFINE_EN
    tm = diag(ONE);
    tm[3*W +: W] = 32'h0005_0000;
    tm[7*W +: W] = 32'h0006_0000;
    tm[11*W +: W] = 32'h0007_0000;
    tbl.push_back('{tm, vec4(ONE, ONE, ONE, ONE), vec4(32'h0006_0000, 32'h0007_0000, 32'h0008_0000, ONE)});
`endif
    foreach (tbl[t]) begin
      send(tbl[t].m, tbl[t].v, tbl[t].e);
      for (int k = 1; k <= LAT + 1; k++) begin
        @(negedge clk_in);
        chk("busy", busy, k <= LAT);
        chk("out_valid_timing", out_valid, k == LAT);
        chk("in_ready_timing", in_ready, k == LAT + 1);
      end
    end
    // backpressure: hold result, ignore a new request, release on out_ready
    out_ready = 0;
    send(diag(32'h0003_0000), vec4(ONE, 32'h0002_0000, 32'h0000_4000, 32'hFFFF_0000),
         model(diag(32'h0003_0000), vec4(ONE, 32'h0002_0000, 32'h0000_4000, 32'hFFFF_0000)));
    for (int k = 1; k <= LAT; k++) @(negedge clk_in);
    chk("bp_out_valid", out_valid, 1);
    snap = out_vec;
    n0 = n_acc;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk_in);
      #1;
      in_valid = (j == 2);
      if (j == 2) begin
        m_in = fill(ONE);
        cur_exp = '1;
      end
      @(negedge clk_in);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_stable", out_vec, snap);
      chk("bp_in_ready_low", in_ready, 0);
    end
    chk("bp_no_accept", n_acc, n0);
    @(posedge clk_in);
    #1;
    out_ready = 1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    // reset in cycle 5 of a job, colliding with in_valid
    send(fill(ONE), vec4(ONE, ONE, ONE, ONE), model(fill(ONE), vec4(ONE, ONE, ONE, ONE)));
    n0 = n_acc;
    repeat (4) begin
      @(posedge clk_in);
      #1;
    end
    rst_in = 1;
    in_valid = 1;
    m_in = diag(ONE);
    cur_exp = '1;
    @(posedge clk_in);
    #1;
    rst_in = 0;
    in_valid = 0;
    sb.delete();
    @(negedge clk_in);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_no_accept", n_acc, n0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      chk("rst_out_valid_low", out_valid, 0);
    end
    @(posedge clk_in);
    #1;
    send(diag(ONE), vec4(32'h0004_0000, 0, 0, 0), vec4(32'h0004_0000, 0, 0, 0));
    wait_out();
    // back-to-back: in_valid and out_ready held high across three jobs
    for (int j = 0; j < 3; j++) begin
      bm[j] = rand_mat();
      bv[j] = rand_vec();
    end
    @(posedge clk_in);
    #1;
    m_in = bm[0];
    v_in = bv[0];
    cur_exp = model(bm[0], bv[0]);
    in_valid = 1;
    for (int j = 0; j < 3; j++) begin
      n0 = n_acc;
      for (int i = 0; i < 40 && n_acc == n0; i++) begin
        @(posedge clk_in);
        #1;
      end
      chk("b2b_accept", n_acc - n0, 1);
      if (j < 2) begin
        m_in = bm[j+1];
        v_in = bv[j+1];
        cur_exp = model(bm[j+1], bv[j+1]);
      end else in_valid = 0;
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk_in);
    chk("b2b_drained", sb.size(), 0);
    chk("b2b_gap1", acc_q[acc_q.size()-2] - acc_q[acc_q.size()-3], LAT + 1);
    chk("b2b_gap2", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], LAT + 1);
    repeat (3) @(negedge clk_in);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mat_vec_sequencer.md
Name: mat_vec_sequencer

Overview:
- Computes a 4x4 matrix × 4-vector transform, as used for vertex transforms in the render pipeline.
- Time-multiplexes a single instance of the team's 3-cycle dotProduct unit (FIXED_POINT=1) across the four matrix rows, one row issued per cycle.
- Sits between the vertex fetch stage and the rasterizer setup stage.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32: element width; signed fixed point with WIDTH/2 fractional bits (Q16.16 by default).
- DP_LATENCY, 3: dotProduct latency in cycles. Fixed by the unit; exposed as a parameter only for assertion checking.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- m_in  input  16*WIDTH  matrix, row-major; element (r,c) at bits [(4r+c)*WIDTH +: WIDTH].
- v_in  input  4*WIDTH  vector; element i at bits [i*WIDTH +: WIDTH].
- in_valid  input  1  m_in/v_in valid.
- in_ready  output  1  block can accept a job.
- out_vec  output  4*WIDTH  result vector; element r = row r · v.
- out_valid  output  1  out_vec valid.
- out_ready  input  1  downstream accepts out_vec.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_vec=0, busy=0, issue counter=0, in-flight tag pipe cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch m_in and v_in into internal regs, go to ISSUE.
  - ISSUE: 4 cycles; row counter r=0..3. dotProduct x-inputs are driven from matrix row r, y-inputs from the latched vector (registered operand muxes). A 2-bit row tag plus valid bit enters a DP_LATENCY-deep shift pipe alongside. After r=3, go to DRAIN.
  - DRAIN: wait until the tag pipe is empty. Each cycle the pipe output is valid, write dotProduct out into result slot [tag].
  - DONE: out_valid=1; out_vec holds the 4 results. On out_ready, return to IDLE.
- Handshake rules:
  - in_ready=0 outside IDLE; single job in flight.
  - out_valid and out_vec stay stable until out_ready is seen; no combinational in→out path.
  - out_ready high before out_valid has no effect.
- Latency: accept edge at cycle 0; row 0 issued in cycle 1; row 3 result captured in cycle 7; out_valid high from cycle 8. With out_ready held high, in_ready returns in cycle 9, giving throughput of 1 vector per 9 cycles.
- Arithmetic:
  - Rounding and overflow are inherited from dotProduct: products truncated to bits [3W/2-1 : W/2], sums wrap modulo 2^WIDTH, no saturation.
  - The sequencer performs no arithmetic itself.
- Boundaries:
  - in_valid during ISSUE/DRAIN/DONE is ignored; the input is not latched.
  - Input changes after the accept edge do not affect the job.
  - rst_in mid-job aborts immediately: tag pipe cleared, results discarded, out_valid=0 next cycle. Late dotProduct outputs are dropped because their tags are gone.
  - rst_in and in_valid in the same cycle: reset wins, nothing is accepted.
  - Matrix or vector of all zeros is legal and gives a zero result in the normal 8 cycles.

Optional Feature:
- Macro: MAT_VEC_AFFINE_EN.
- Defined: the matrix is treated as affine. Only rows 0..2 are issued. out_vec[3] is forced to v_in[3], passed through unchanged. ISSUE lasts 3 cycles, out_valid rises in cycle 7, and m_in row 3 is ignored.
- Undefined: full 4-row behaviour as above.

Decomposition:
- Package mat_vec_pkg holds:
  - state enum typedef (IDLE, ISSUE, DRAIN, DONE);
  - row-tag typedef (2 bits);
  - NUM_ROWS=4 constant;
  - helper functions for packing and unpacking matrix rows and vector elements.
- One natural sub-module: mat_vec_tag_pipe, a parameterised DP_LATENCY-deep valid+tag shift register with synchronous clear. It is reusable for other dotProduct users.

Test Plan:
- Identity matrix (diagonal 0x00010000), v=(1.0, 2.0, -3.0, 0.5) → out_vec=(0x00010000, 0x00020000, 0xFFFD0000, 0x00008000); out_valid first high exactly 8 cycles after accept.
- Matrix of all 2.0, v=(1.0, 1.0, 1.0, 1.0) → every element 0x00080000 (8.0); busy high cycles 1-8.
- Backpressure: out_ready held low for 5 cycles after out_valid → out_vec stable, in_ready stays 0, and a new in_valid pulse is ignored. out_ready=1 → in_ready=1 the next cycle.
- Reset asserted in cycle 5 of a job → out_valid never rises; the next job (identity matrix, v=(4.0, 0, 0, 0)) returns exactly (0x00040000, 0, 0, 0) with no stale slots.
- Back-to-back: in_valid held high and out_ready high for 3 jobs → jobs accepted at cycles 0, 9, 18 with correct, in-order results.
- MAT_VEC_AFFINE_EN defined, translate matrix (identity with column 3 = 5.0, 6.0, 7.0), v=(1.0, 1.0, 1.0, 1.0) → out_vec=(6.0, 7.0, 8.0, 1.0); out_valid in cycle 7.
